add_share_arbiter: RTL and testbench

- Shares one `dut` adder (two 8-bit operand channels in, one 9-bit sum channel out, busy/vld handshakes) among N_REQ requesters.
- Round-robin arbitration selects a requester and issues its operand pair to din_1/din_2.
- The granted requester index is recorded in an in-order tag FIFO, and each dout result is routed back to the requester that issued it.
- Sits between requester blocks and the adder instance in the same clock domain.

---
 rtl/add_share_arbiter_pkg.sv | 28 ++
 rtl/add_share_tag_fifo.sv | 69 ++++++
 rtl/add_share_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_add_share_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// add_share_arbiter_pkg
//   Shared definitions for the adder-sharing arbiter:
//     DATA_W_DEF / SUM_W_DEF : default operand and sum widths
//     tag_t                  : requester tag container (wide enough for 16)
//     tag_width()            : tag width for a given requester count
//     rr_next()              : round-robin pointer successor
// ---------------------------------------------------------------------------
package add_share_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF  = DATA_W_DEF + 1;
  localparam int MAX_REQ    = 16;
  localparam int TAG_W_MAX  = 4;

  typedef logic [TAG_W_MAX-1:0] tag_t;

  // Tag width is never zero, even for a degenerate single requester.
  function automatic int tag_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Pointer moves to the requester just after the one granted.
  function automatic int rr_next(input int g, input int n_req);
    return (g + 1) % n_req;
  endfunction

endpackage

// File: rtl/add_share_tag_fifo.sv
// ---------------------------------------------------------------------------
// add_share_tag_fifo
//   In-order FIFO of requester tags, one entry per transaction in flight.
//   The head is read combinationally so the response path has no added
//   latency.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     push, push_tag  write a tag (caller guarantees not full)
//     pop             drop the head entry (caller guarantees not empty)
//     head            tag at the head of the queue
//     count           number of stored entries (0..DEPTH)
//     empty           count == 0
// ---------------------------------------------------------------------------
module add_share_tag_fifo
  import add_share_arbiter_pkg::*;
#(
  parameter int TAG_W = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     pop,
  output logic [TAG_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/add_share_arbiter.sv
// ---------------------------------------------------------------------------
// add_share_arbiter
//   Shares a single two-operand adder among N_REQ requesters. A round-robin
//   arbiter picks one requester, its operand pair is held in an issue
//   register and offered on din_1/din_2 (each port completes independently),
//   and the granted index is queued so that each adder result is steered
//   back to the requester that issued it.
//
//   Optional build macro ADD_SHARE_ARBITER_STATS_EN adds stat_grants,
//   stat_results (wrapping 16-bit counters) and stat_err (sticky flag for a
//   result arriving with nothing in flight).
//
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     req_vld/req_busy/req_a/req_b     requester operand channels (packed)
//     din_1_*, din_2_*                 operand channels to the adder
//     dout_vld/dout_busy/dout_data     sum channel from the adder
//     rsp_vld/rsp_busy/rsp_data        per-requester result, data broadcast
// ---------------------------------------------------------------------------
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  output logic [N_REQ-1:0]          req_busy,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic                      din_1_vld,
  input  logic                      din_1_busy,
  output logic [DATA_W-1:0]         din_1_data,
  output logic                      din_2_vld,
  input  logic                      din_2_busy,
  output logic [DATA_W-1:0]         din_2_data,
  input  logic                      dout_vld,
  output logic                      dout_busy,
  input  logic [DATA_W:0]           dout_data,
  output logic [N_REQ-1:0]          rsp_vld,
  input  logic [N_REQ-1:0]          rsp_busy,
  output logic [DATA_W:0]           rsp_data
`ifdef ADD_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]               stat_grants,
  output logic [15:0]               stat_results,
  output logic                      stat_err
`endif
);

  localparam int TAG_W     = tag_width(N_REQ);
  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam int SUM_PTR_W = TAG_W + 1;

  // Unpacked views of the requester operand buses.
  logic [DATA_W-1:0] a_arr [N_REQ];
  logic [DATA_W-1:0] b_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  // Issue stage state.
  logic              iss_vld_reg;
  logic [DATA_W-1:0] iss_a_reg;
  logic [DATA_W-1:0] iss_b_reg;
  logic              d1_done_reg;
  logic              d2_done_reg;
  logic [TAG_W-1:0]  rr_ptr_reg;

  // Tag FIFO interface.
  logic              push;
  logic              pop;
  logic [TAG_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic              empty;

  // ------------------------------------------------------------------
  // Round-robin winner: rotate req_vld so bit 0 is the rr_ptr position,
  // take the first set bit, then map the offset back to an index.
  // ------------------------------------------------------------------
  logic [2*N_REQ-1:0]   req_dbl;
  logic [N_REQ-1:0]     req_rot;
  logic                 found;
  logic [SUM_PTR_W-1:0] win_sum;
  logic [TAG_W-1:0]     winner;
  logic                 can_grant;
  logic                 grant;

  assign req_dbl = {req_vld, req_vld};
  assign req_rot = req_dbl[{1'b0, rr_ptr_reg} +: N_REQ];

  always_comb begin
    found   = 1'b0;
    win_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        win_sum = {1'b0, rr_ptr_reg} + SUM_PTR_W'(k);
      end
    end
    if (win_sum >= SUM_PTR_W'(N_REQ)) begin
      win_sum = win_sum - SUM_PTR_W'(N_REQ);
    end
  end

  assign winner = win_sum[TAG_W-1:0];

  // Grants wait for the issue register to drain completely; a result pop
  // in the same cycle is deliberately not counted towards free space.
  assign can_grant = ~iss_vld_reg & (count < CNT_W'(DEPTH));
  assign grant     = ~rst & can_grant & found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_busy
    assign req_busy[gi] = ~(grant & (winner == TAG_W'(gi)));
  end

  // ------------------------------------------------------------------
  // Issue stage: each operand port completes on its own; the pair
  // retires on the edge where the second (or both) transfer.
  // ------------------------------------------------------------------
  logic d1_xfer;
  logic d2_xfer;
  logic d1_now;
  logic d2_now;

  assign din_1_vld  = iss_vld_reg & ~d1_done_reg;
  assign din_2_vld  = iss_vld_reg & ~d2_done_reg;
  assign din_1_data = iss_a_reg;
  assign din_2_data = iss_b_reg;

  assign d1_xfer = din_1_vld & ~din_1_busy;
  assign d2_xfer = din_2_vld & ~din_2_busy;
  assign d1_now  = d1_done_reg | d1_xfer;
  assign d2_now  = d2_done_reg | d2_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_reg <= 1'b0;
      iss_a_reg   <= '0;
      iss_b_reg   <= '0;
      d1_done_reg <= 1'b0;
      d2_done_reg <= 1'b0;
      rr_ptr_reg  <= '0;
    end else if (iss_vld_reg) begin
      if (d1_now && d2_now) begin
        iss_vld_reg <= 1'b0;
        d1_done_reg <= 1'b0;
        d2_done_reg <= 1'b0;
      end else begin
        d1_done_reg <= d1_now;
        d2_done_reg <= d2_now;
      end
    end else if (grant) begin
      iss_vld_reg <= 1'b1;
      iss_a_reg   <= a_arr[winner];
      iss_b_reg   <= b_arr[winner];
      rr_ptr_reg  <= TAG_W'(rr_next(int'(winner), N_REQ));
    end
  end

  // ------------------------------------------------------------------
  // Tag FIFO and response steering. Results return in issue order, so
  // the head tag always names the owner of the current dout.
  // ------------------------------------------------------------------
  assign push = grant;
  assign pop  = dout_vld & ~dout_busy;

  add_share_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (winner),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .empty    (empty)
  );

  // With nothing in flight the adder output is stalled, never dropped.
  assign dout_busy = rst | empty | rsp_busy[head];
  assign rsp_data  = dout_data;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
    assign rsp_vld[gi] = dout_vld & ~empty & (head == TAG_W'(gi));
  end

`ifdef ADD_SHARE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants  <= '0;
      stat_results <= '0;
      stat_err     <= 1'b0;
    end else begin
      if (grant) begin
        stat_grants <= stat_grants + 16'd1;
      end
      if (pop) begin
        stat_results <= stat_results + 16'd1;
      end
      if (dout_vld && empty) begin
        stat_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_share_arbiter
//   Drives four requesters and a behavioural two-port adder around the
//   arbiter. A monitor predicts the round-robin winner and the sum for every
//   grant, queues the expectation, and pops it when a result is delivered.
// ---------------------------------------------------------------------------
module tb_add_share_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int SW    = DW + 1;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_busy;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            din_1_vld;
  logic            din_1_busy;
  logic [DW-1:0]   din_1_data;
  logic            din_2_vld;
  logic            din_2_busy;
  logic [DW-1:0]   din_2_data;
  logic            dout_vld;
  logic            dout_busy;
  logic [SW-1:0]   dout_data;
  logic [N-1:0]    rsp_vld;
  logic [N-1:0]    rsp_busy;
  logic [SW-1:0]   rsp_data;
`ifdef ADD_SHARE_ARBITER_STATS_EN
  logic [15:0]     stat_grants;
  logic [15:0]     stat_results;
  logic            stat_err;
`endif

  always #5 clk = ~clk;

  add_share_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_busy   (req_busy),
    .req_a      (req_a),
    .req_b      (req_b),
    .din_1_vld  (din_1_vld),
    .din_1_busy (din_1_busy),
    .din_1_data (din_1_data),
    .din_2_vld  (din_2_vld),
    .din_2_busy (din_2_busy),
    .din_2_data (din_2_data),
    .dout_vld   (dout_vld),
    .dout_busy  (dout_busy),
    .dout_data  (dout_data),
    .rsp_vld    (rsp_vld),
    .rsp_busy   (rsp_busy),
    .rsp_data   (rsp_data)
`ifdef ADD_SHARE_ARBITER_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_results (stat_results),
    .stat_err     (stat_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- requester and adder stimulus state ----------------
  bit            have_req [N];
  logic [DW-1:0] qa [N];
  logic [DW-1:0] qb [N];
  bit            rb [N];
  bit            req_en    = 1'b0;
  int            req_pct   = 50;
  int            p1 = 0, p2 = 0, dout_pct = 100, rspb_pct = 0;

  bit            a_got, b_got, out_v;
  logic [DW-1:0] ga, gb;
  logic [SW-1:0] res_q [$];

  for (genvar gi = 0; gi < N; gi++) begin : g_drv
    assign req_vld[gi]         = have_req[gi];
    assign req_a[gi*DW +: DW]  = qa[gi];
    assign req_b[gi*DW +: DW]  = qb[gi];
    assign rsp_busy[gi]        = rb[gi];
  end

  // Requesters and adder model: transfers are decided from values stable
  // at the falling edge, state is updated just after the rising edge.
  initial begin : driver
    bit x_req [N];
    bit x_d1, x_d2, x_dout;
    logic [DW-1:0] ca, cb;
    for (int i = 0; i < N; i++) begin
      have_req[i] = 1'b0; qa[i] = '0; qb[i] = '0; rb[i] = 1'b0;
    end
    din_1_busy = 1'b0; din_2_busy = 1'b0; dout_vld = 1'b0; dout_data = '0;
    a_got = 1'b0; b_got = 1'b0; out_v = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) x_req[i] = !rst && req_vld[i] && !req_busy[i];
      x_d1   = !rst && din_1_vld && !din_1_busy;
      x_d2   = !rst && din_2_vld && !din_2_busy;
      x_dout = !rst && dout_vld && !dout_busy;
      ca = din_1_data;
      cb = din_2_data;
      @(posedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < N; i++) have_req[i] = 1'b0;
        a_got = 1'b0; b_got = 1'b0; out_v = 1'b0;
        res_q.delete();
      end else begin
        for (int i = 0; i < N; i++) if (x_req[i]) have_req[i] = 1'b0;
        if (x_d1) begin a_got = 1'b1; ga = ca; end
        if (x_d2) begin b_got = 1'b1; gb = cb; end
        if (x_dout) begin void'(res_q.pop_front()); out_v = 1'b0; end
        if (a_got && b_got) begin
          res_q.push_back(SW'(ga) + SW'(gb));
          a_got = 1'b0; b_got = 1'b0;
        end
        if (!out_v && res_q.size() > 0 && $urandom_range(99) < dout_pct) out_v = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (!have_req[i] && req_en && $urandom_range(99) < req_pct) begin
            qa[i] = DW'($urandom); qb[i] = DW'($urandom); have_req[i] = 1'b1;
          end
        end
      end
      din_1_busy = a_got || ($urandom_range(99) < p1);
      din_2_busy = b_got || ($urandom_range(99) < p2);
      dout_vld   = out_v;
      dout_data  = out_v ? res_q[0] : '0;
      for (int i = 0; i < N; i++) rb[i] = ($urandom_range(99) < rspb_pct);
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int idx; int sum; } exp_t;
  exp_t exp_q [$];
  int   last_g = -1;
  int   n_grants = 0;
  int   glog [$];
  bit   op1_pend = 1'b0, op2_pend = 1'b0;
  int   cur_a, cur_b;
  int   last_rsp_idx = -1, last_rsp_data = -1;

  initial begin : monitor
    int g, ew, j;
    bit pend;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); glog.delete();
        last_g = -1; op1_pend = 1'b0; op2_pend = 1'b0;
      end else begin
        pend = op1_pend || op2_pend;
        if (din_1_vld && !din_1_busy) begin
          chk("din1_expected", int'(op1_pend), 1);
          chk("din1_data", int'(din_1_data), cur_a);
          op1_pend = 1'b0;
        end
        if (din_2_vld && !din_2_busy) begin
          chk("din2_expected", int'(op2_pend), 1);
          chk("din2_data", int'(din_2_data), cur_b);
          op2_pend = 1'b0;
        end
        g = -1;
        for (int i = 0; i < N; i++) if (req_vld[i] && !req_busy[i]) g = i;
        if (g >= 0) begin
          chk("grant_onehot", $countones(~req_busy), 1);
          chk("grant_while_issuing", int'(pend), 0);
          chk("inflight_limit", int'(exp_q.size() < DEPTH), 1);
          ew = -1;
          for (int k = 0; k < N; k++) begin
            j = (last_g + 1 + k) % N;
            if (ew < 0 && req_vld[j]) ew = j;
          end
          chk("rr_winner", g, ew);
          cur_a = int'(qa[g]); cur_b = int'(qb[g]);
          exp_q.push_back('{g, cur_a + cur_b});
          op1_pend = 1'b1; op2_pend = 1'b1;
          last_g = g; n_grants++; glog.push_back(g);
        end
        if (rsp_vld != '0) begin
          chk("rsp_onehot", $countones(rsp_vld), 1);
          for (int i = 0; i < N; i++) begin
            if (rsp_vld[i] && !rsp_busy[i]) begin
              if (exp_q.size() == 0) begin
                chk("rsp_unexpected", i, -1);
              end else begin
                e = exp_q.pop_front();
                chk("rsp_idx", i, e.idx);
                chk("rsp_sum", int'(rsp_data), e.sum);
                last_rsp_idx = i; last_rsp_data = int'(rsp_data);
                $display("rsp req=%0d sum=0x%03h", i, rsp_data);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- directed and random sequences ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic load_req(int i, int a, int b);
    qa[i] = DW'(a); qb[i] = DW'(b); have_req[i] = 1'b1;
  endtask

  function automatic bit all_idle();
    bit r = (exp_q.size() == 0) && (res_q.size() == 0) && !op1_pend && !op2_pend;
    for (int i = 0; i < N; i++) if (have_req[i]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_grants(int target, int budget);
    int t = 0;
    while (n_grants < target && t < budget) begin @(negedge clk); #1; t++; end
    if (n_grants < target) begin
      n_checks++;
      $display("FAIL wait_grants: got %0d grants, required %0d", n_grants, target);
    end
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (!all_idle() && t < budget) begin @(negedge clk); #1; t++; end
    if (!all_idle()) begin
      n_checks++;
      $display("FAIL wait_idle: still busy after %0d cycles, %0d results pending", budget, exp_q.size());
    end
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
  endtask

  initial begin : main
    int base;
    int order [5] = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_busy", int'(req_busy), 'hF);
    chk("rst_din1_vld", int'(din_1_vld), 0);
    chk("rst_din2_vld", int'(din_2_vld), 0);
    chk("rst_dout_busy", int'(dout_busy), 1);
    chk("rst_rsp_vld", int'(rsp_vld), 0);
    chk("rst_din1_data", int'(din_1_data), 0);
    chk("rst_din2_data", int'(din_2_data), 0);
    step(); rst = 1'b0;

    // Single request: grant at T, operands at T+1, result to requester 2
    step(); load_req(2, 'h7F, 'h01);
    @(negedge clk);
    chk("single_grant", int'(req_busy), 'b1011);
    @(negedge clk);
    chk("single_din1_vld", int'(din_1_vld), 1);
    chk("single_din1_data", int'(din_1_data), 'h7F);
    chk("single_din2_data", int'(din_2_data), 'h01);
    wait_idle(50);
    chk("single_rsp_idx", last_rsp_idx, 2);
    chk("single_rsp_data", last_rsp_data, 'h080);

    // Carry out of the top bit
    step(); load_req(0, 'hFF, 'hFF);
    wait_idle(50);
    chk("ovf_rsp_idx", last_rsp_idx, 0);
    chk("ovf_rsp_data", last_rsp_data, 'h1FE);

    // Fairness from a fresh pointer
    do_reset();
    base = n_grants;
    for (int i = 0; i < N; i++) load_req(i, 16 * i + 3, 7 * i + 1);
    wait_grants(base + 4, 100);
    step(); load_req(0, 'h55, 'hAA);
    wait_grants(base + 5, 100);
    wait_idle(100);
    chk("fair_count", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk("fair_order", glog[k], order[k]);

    // Split port acceptance: port 2 stalled for three cycles
    p2 = 100;
    step(); load_req(1, 'h12, 'h34);
    @(negedge clk);
    chk("split_grant", int'(req_busy), 'b1101);
    @(negedge clk);
    chk("split_vld_both", int'({din_1_vld, din_2_vld}), 'b11);
    step(); load_req(3, 'h21, 'h43);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("split_vld_d2_only", int'({din_1_vld, din_2_vld}), 'b01);
      chk("split_no_grant", int'(req_busy), 'hF);
    end
    step(); p2 = 0;
    wait_idle(100);

    // Full tag FIFO: results held back, grants must stop at DEPTH
    step(); rspb_pct = 100;
    base = n_grants;
    for (int i = 0; i < N; i++) load_req(i, 'h80 + i, 'h40 + i);
    wait_grants(base + 4, 100);
    step(); load_req(0, 'h01, 'h02); load_req(2, 'h03, 'h04);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("full_blocked", int'(req_busy), 'hF);
    end
    chk("full_inflight", exp_q.size(), DEPTH);
    step(); rspb_pct = 0;
    wait_grants(base + 6, 200);
    wait_idle(200);

    // Reset with two transactions outstanding
    step(); rspb_pct = 100;
    base = n_grants;
    load_req(1, 'h11, 'h22); load_req(3, 'h33, 'h44);
    wait_grants(base + 2, 100);
    step(); rst = 1'b1;
    @(negedge clk);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_busy", int'(req_busy), 'hF);
    chk("midrst_din_vld", int'({din_1_vld, din_2_vld}), 0);
    chk("midrst_dout_busy", int'(dout_busy), 1);
    step(); rspb_pct = 0; load_req(2, 'h05, 'h06); load_req(3, 'h07, 'h08);
    @(negedge clk);
    chk("midrst_first_grant", int'(req_busy), 'b1011);
    wait_idle(100);

    // Randomised traffic with random back-pressure on every channel
    step(); req_en = 1'b1; p1 = 30; p2 = 30; dout_pct = 60; rspb_pct = 30;
    repeat (1500) @(posedge clk);
    step(); req_en = 1'b0;
    wait_idle(600);
    p1 = 0; p2 = 0; dout_pct = 100; rspb_pct = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
